// File: rtl/time_set_ctrl.sv
// Front-panel time-set controller: button synchronizers, debouncers and the RUN/SETH/SETM set-mode FSM.
// Optional set-state timeout back to RUN is built when SET_TIMEOUT_EN is defined.
module time_set_ctrl #(
  parameter int unsigned DEB_CNT   = 20,
  parameter int unsigned REP_DLY   = 500,
  parameter int unsigned REP_PER   = 100,
  parameter int unsigned BLINK_PER = 250,
  parameter int unsigned TMO_CNT   = 10000,
  parameter int unsigned CW        = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       MODE_BTN,
  input  logic       SET_BTN,
  output logic       HINC,
  output logic       MINC,
  output logic       SCLR,
  output logic       RUN,
  output logic [1:0] MODE,
  output logic       BLINK
);

  typedef enum logic [1:0] {ST_RUN = 2'b00, ST_SETH = 2'b01, ST_SETM = 2'b10} state_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] DEB_C   = CW'(DEB_CNT);
  localparam logic [CW-1:0] DLY_C   = CW'(REP_DLY);
  localparam logic [CW-1:0] PER_C   = CW'(REP_PER);
  localparam logic [CW-1:0] BLK_C   = CW'(BLINK_PER);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // bit 0 = MODE button, bit 1 = SET button
  logic [1:0]         sync1_r, sync2_r, lvl_r, prev_r, lvl_nxt_s;
  logic [1:0][CW-1:0] deb_cnt_r, deb_cnt_nxt_s;
  logic               mode_evt_s, set_evt_s, set_state_s, pulse_s;
  state_t             state_r, state_nxt_s;
  logic               hinc_r, minc_r, sclr_r, run_r, blink_r;
  logic               hinc_nxt_s, minc_nxt_s, sclr_nxt_s, blink_nxt_s;
  logic               rep_act_r, rep_first_r, rep_act_nxt_s, rep_first_nxt_s;
  logic [CW-1:0]      rep_cnt_r, rep_cnt_nxt_s, blink_cnt_r, blink_cnt_nxt_s, rep_thr_s;
  logic               tmo_hit_s;

  // Debounce: level flips once the synchronized input has differed for DEB_CNT ticks
  always_comb begin
    lvl_nxt_s     = lvl_r;
    deb_cnt_nxt_s = deb_cnt_r;
    for (int i = 0; i < 2; i++) begin
      if (sync2_r[i] == lvl_r[i]) begin
        deb_cnt_nxt_s[i] = '0;
      end else if (TICK) begin
        if (sat_inc(deb_cnt_r[i]) >= DEB_C) begin
          lvl_nxt_s[i]     = ~lvl_r[i];
          deb_cnt_nxt_s[i] = '0;
        end else begin
          deb_cnt_nxt_s[i] = sat_inc(deb_cnt_r[i]);
        end
      end else begin
        deb_cnt_nxt_s[i] = deb_cnt_r[i];
      end
    end
  end

  assign mode_evt_s  = lvl_r[0] & ~prev_r[0];
  assign set_evt_s   = lvl_r[1] & ~prev_r[1];
  assign set_state_s = (state_r != ST_RUN);
  assign rep_thr_s   = rep_first_r ? DLY_C : PER_C;

`ifdef SET_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_C = CW'(TMO_CNT);
  logic [CW-1:0] tmo_cnt_r, tmo_cnt_nxt_s;

  // Idle timer in set states; any press or state change restarts it
  always_comb begin
    tmo_hit_s = set_state_s & TICK & (sat_inc(tmo_cnt_r) >= TMO_C);
    if (!set_state_s || mode_evt_s || set_evt_s || (state_nxt_s != state_r)) begin
      tmo_cnt_nxt_s = '0;
    end else if (TICK) begin
      tmo_cnt_nxt_s = sat_inc(tmo_cnt_r);
    end else begin
      tmo_cnt_nxt_s = tmo_cnt_r;
    end
  end

  // Timeout counter register
  always_ff @(posedge CLK) begin
    if (RST) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_nxt_s;
    end
  end
`else
  logic tmo_unused_s;
  assign tmo_hit_s    = 1'b0;
  assign tmo_unused_s = (TMO_CNT != 32'd0);
`endif

  // Next state, set pulses, auto-repeat and blink; MODE press outranks SET press and timeout
  always_comb begin
    state_nxt_s     = state_r;
    hinc_nxt_s      = 1'b0;
    minc_nxt_s      = 1'b0;
    sclr_nxt_s      = 1'b0;
    pulse_s         = 1'b0;
    rep_act_nxt_s   = rep_act_r;
    rep_first_nxt_s = rep_first_r;
    rep_cnt_nxt_s   = rep_cnt_r;
    blink_nxt_s     = blink_r;
    blink_cnt_nxt_s = blink_cnt_r;
    if (mode_evt_s) begin
      rep_act_nxt_s = 1'b0;
      case (state_r)
        ST_RUN:  state_nxt_s = ST_SETH;
        ST_SETH: state_nxt_s = ST_SETM;
        ST_SETM: begin
          state_nxt_s = ST_RUN;
          sclr_nxt_s  = 1'b1;
        end
        default: state_nxt_s = ST_RUN;
      endcase
    end else if (set_evt_s && set_state_s) begin
      pulse_s         = 1'b1;
      rep_act_nxt_s   = 1'b1;
      rep_first_nxt_s = 1'b1;
      rep_cnt_nxt_s   = TICK ? CNT_ONE : '0;
    end else if (tmo_hit_s) begin
      state_nxt_s   = ST_RUN;
      rep_act_nxt_s = 1'b0;
    end else if (rep_act_r) begin
      // Look at the next debounced level so the release cycle never carries a pulse
      if (!lvl_nxt_s[1]) begin
        rep_act_nxt_s = 1'b0;
      end else if (TICK) begin
        if (sat_inc(rep_cnt_r) >= rep_thr_s) begin
          pulse_s         = 1'b1;
          rep_first_nxt_s = 1'b0;
          rep_cnt_nxt_s   = '0;
        end else begin
          rep_cnt_nxt_s = sat_inc(rep_cnt_r);
        end
      end else begin
        rep_cnt_nxt_s = rep_cnt_r;
      end
    end else begin
      rep_act_nxt_s = 1'b0;
    end
    hinc_nxt_s = pulse_s & (state_r == ST_SETH);
    minc_nxt_s = pulse_s & (state_r == ST_SETM);
    if ((state_nxt_s == ST_RUN) || (state_nxt_s != state_r) || pulse_s) begin
      blink_nxt_s     = 1'b0;
      blink_cnt_nxt_s = '0;
    end else if (TICK) begin
      if (sat_inc(blink_cnt_r) >= BLK_C) begin
        blink_nxt_s     = ~blink_r;
        blink_cnt_nxt_s = '0;
      end else begin
        blink_cnt_nxt_s = sat_inc(blink_cnt_r);
      end
    end else begin
      blink_cnt_nxt_s = blink_cnt_r;
    end
  end

  // State, synchronizer, debounce and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_r     <= 2'b00;
      sync2_r     <= 2'b00;
      lvl_r       <= 2'b00;
      prev_r      <= 2'b00;
      deb_cnt_r   <= '0;
      state_r     <= ST_RUN;
      hinc_r      <= 1'b0;
      minc_r      <= 1'b0;
      sclr_r      <= 1'b0;
      run_r       <= 1'b1;
      blink_r     <= 1'b0;
      blink_cnt_r <= '0;
      rep_act_r   <= 1'b0;
      rep_first_r <= 1'b0;
      rep_cnt_r   <= '0;
    end else begin
      sync1_r     <= {SET_BTN, MODE_BTN};
      sync2_r     <= sync1_r;
      lvl_r       <= lvl_nxt_s;
      prev_r      <= lvl_r;
      deb_cnt_r   <= deb_cnt_nxt_s;
      state_r     <= state_nxt_s;
      hinc_r      <= hinc_nxt_s;
      minc_r      <= minc_nxt_s;
      sclr_r      <= sclr_nxt_s;
      run_r       <= (state_nxt_s == ST_RUN);
      blink_r     <= blink_nxt_s;
      blink_cnt_r <= blink_cnt_nxt_s;
      rep_act_r   <= rep_act_nxt_s;
      rep_first_r <= rep_first_nxt_s;
      rep_cnt_r   <= rep_cnt_nxt_s;
    end
  end

  assign HINC  = hinc_r;
  assign MINC  = minc_r;
  assign SCLR  = sclr_r;
  assign RUN   = run_r;
  assign MODE  = state_r;
  assign BLINK = blink_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed self-checking bench for time_set_ctrl (DEB_CNT=4, REP_DLY=8, REP_PER=2, BLINK_PER=5, TMO_CNT=30).
// Timeout expectations follow SET_TIMEOUT_EN.
module tb_time_set_ctrl;

  logic       CLK = 1'b0;
  logic       RST, TICK, MODE_BTN, SET_BTN;
  logic       HINC, MINC, SCLR, RUN, BLINK;
  logic [1:0] MODE;

  int checks = 0;
  int errors = 0;
  int hinc_n = 0, minc_n = 0, sclr_n = 0, bad_n = 0, sclr_bad_n = 0, mchg_n = 0;
  logic [1:0] mode_q = 2'b00;
  int h0, m0, s0, c0;

  time_set_ctrl #(
    .DEB_CNT(4), .REP_DLY(8), .REP_PER(2), .BLINK_PER(5), .TMO_CNT(30), .CW(16)
  ) dut (
    .CLK(CLK), .RST(RST), .TICK(TICK), .MODE_BTN(MODE_BTN), .SET_BTN(SET_BTN),
    .HINC(HINC), .MINC(MINC), .SCLR(SCLR), .RUN(RUN), .MODE(MODE), .BLINK(BLINK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse counters and cycle-level illegal-combination tallies
  always @(negedge CLK) begin
    mode_q <= MODE;
    if (!RST) begin
      if (HINC === 1'b1) hinc_n <= hinc_n + 1;
      if (MINC === 1'b1) minc_n <= minc_n + 1;
      if (SCLR === 1'b1) sclr_n <= sclr_n + 1;
      if ((HINC & MINC) || ((HINC | MINC) & RUN)) bad_n <= bad_n + 1;
      if (SCLR && (MODE != 2'b00 || !RUN)) sclr_bad_n <= sclr_bad_n + 1;
      if (MODE !== mode_q) mchg_n <= mchg_n + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; MODE_BTN = 1'b0; SET_BTN = 1'b0;
    cyc(3);
    RST = 1'b0;
    cyc(1);
  endtask

  task automatic press_mode();
    MODE_BTN = 1'b1; cyc(7); MODE_BTN = 1'b0; cyc(9);
  endtask

  task automatic press_set();
    SET_BTN = 1'b1; cyc(7); SET_BTN = 1'b0; cyc(9);
  endtask

  task automatic snap();
    h0 = hinc_n; m0 = minc_n; s0 = sclr_n; c0 = mchg_n;
  endtask

  initial begin
    TICK = 1'b1;
    // Reset values
    RST = 1'b1; MODE_BTN = 1'b0; SET_BTN = 1'b0;
    cyc(3);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_hinc", HINC, 0); check("rst_minc", MINC, 0); check("rst_sclr", SCLR, 0);
    check("rst_run", RUN, 1);   check("rst_mode", MODE, 0); check("rst_blink", BLINK, 0);

    // Bounce rejection, then a clean press and one SET in SETH
    cyc(2); snap();
    MODE_BTN = 1'b1; cyc(3); MODE_BTN = 1'b0; cyc(10);
    check("glitch_mode", MODE, 0);
    check("glitch_chg", mchg_n - c0, 0);
    press_mode();
    check("bounce_mode", MODE, 1);
    check("bounce_chg", mchg_n - c0, 1);
    check("bounce_run", RUN, 0);
    snap(); press_set(); cyc(2);
    check("seth_hinc", hinc_n - h0, 1);
    check("seth_minc", minc_n - m0, 0);

    // Full MODE cycle with seconds clear, then SET ignored in RUN
    do_reset(); snap();
    press_mode(); check("cyc_mode1", MODE, 1); check("cyc_run1", RUN, 0);
    press_mode(); check("cyc_mode2", MODE, 2); check("cyc_sclr2", sclr_n - s0, 0);
    press_mode(); check("cyc_mode0", MODE, 0); check("cyc_run0", RUN, 1);
    cyc(2);
    check("cyc_sclr", sclr_n - s0, 1);
    snap(); press_set(); cyc(2);
    check("run_set_hinc", hinc_n - h0, 0);
    check("run_set_minc", minc_n - m0, 0);
    check("run_set_mode", MODE, 0);

    // Auto-repeat in SETM; SET raw set in cycle n, press event at n+6
    do_reset(); press_mode(); press_mode();
    check("rep_mode", MODE, 2);
    SET_BTN = 1'b1;
    for (int c = 0; c <= 34; c++) begin
      @(negedge CLK);
      check($sformatf("rep_minc_c%0d", c), MINC,
            (c == 7 || (c >= 14 && c <= 26 && c % 2 == 0)) ? 1 : 0);
      check($sformatf("rep_hinc_c%0d", c), HINC, 0);
      if (c >= 7)
        check($sformatf("rep_blink_c%0d", c), BLINK, (c == 12 || c == 13 || c >= 31) ? 1 : 0);
      if (c == 22) SET_BTN = 1'b0;
    end

    // MODE and SET debounce-rise together in SETH
    do_reset(); press_mode(); snap();
    MODE_BTN = 1'b1; SET_BTN = 1'b1; cyc(7);
    MODE_BTN = 1'b0; SET_BTN = 1'b0; cyc(9);
    check("sim_mode", MODE, 2);
    check("sim_hinc", hinc_n - h0, 0);
    check("sim_minc", minc_n - m0, 0);

    // Idle in SETH; state entered at c=7
    do_reset(); snap();
    MODE_BTN = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge CLK);
      if (c == 6) MODE_BTN = 1'b0;
      if (c == 7)  check("tmo_enter", MODE, 1);
      if (c == 11) check("tmo_blink0", BLINK, 0);
      if (c == 12) check("tmo_blink1", BLINK, 1);
      if (c == 36) check("tmo_pre", MODE, 1);
`ifdef SET_TIMEOUT_EN
      if (c == 37) begin check("tmo_mode", MODE, 0); check("tmo_run", RUN, 1); end
`else
      if (c == 37) begin check("tmo_mode", MODE, 1); check("tmo_run", RUN, 0); end
`endif
    end
    cyc(1);
    check("tmo_sclr", sclr_n - s0, 0);

    check("never_both_or_run", bad_n, 0);
    check("sclr_in_run", sclr_bad_n, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
